// File: rtl/hc_pkg.sv
// Shared types and helpers for the multi-channel hysteresis comparator.
// The difference helper is sized for the widest supported sample so no subtraction can wrap.
package hc_pkg;

    localparam int unsigned CW   = 8;
    localparam int unsigned MaxW = 64;

    typedef enum logic [1:0] {
        StLow      = 2'd0,
        StRisePend = 2'd1,
        StHigh     = 2'd2,
        StFallPend = 2'd3
    } state_e;

    // Two extra bits of headroom keep a - b and its negation exact.
    function automatic logic signed [MaxW+1:0] diff_ext(
        input logic signed [MaxW-1:0] x,
        input logic signed [MaxW-1:0] y
    );
        logic signed [MaxW+1:0] xe;
        logic signed [MaxW+1:0] ye;
        xe = {{2{x[MaxW-1]}}, x};
        ye = {{2{y[MaxW-1]}}, y};
        return xe - ye;
    endfunction

endpackage

// File: rtl/hc_chan.sv
// One hysteresis channel: signed compare against a threshold plus a persistence FSM.
// The output flips only after HOLD consecutive valid samples meet the opposing condition.
module hc_chan
    import hc_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned HOLD = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] th,
    output logic         out,
    output logic         out_nxt,
    output logic         flip
);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                flip_q;
    logic signed [MaxW-1:0] a_ext, b_ext;
    logic signed [MaxW+1:0] d, d_neg, th_ext;
    logic                set_c, clr_c, last_c;

    assign a_ext  = {{(MaxW - W){a[W-1]}}, a};
    assign b_ext  = {{(MaxW - W){b[W-1]}}, b};
    assign d      = diff_ext(a_ext, b_ext);
    assign d_neg  = -d;
    assign th_ext = {{(MaxW + 2 - W){1'b0}}, th};
    assign set_c  = d > th_ext;
    assign clr_c  = d_neg > th_ext;
    assign last_c = (cnt_q == CW'(HOLD - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StLow;
            cnt_q   <= '0;
            flip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flip_q  <= (out_nxt != out);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StLow: begin
                if (in_valid && set_c) begin
                    if (HOLD == 1) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end else begin
                        state_d = StRisePend;
                        cnt_d   = CW'(1);
                    end
                end
            end
            StRisePend: begin
                if (in_valid) begin
                    if (set_c && last_c) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end else if (set_c) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        state_d = StLow;
                        cnt_d   = '0;
                    end
                end
            end
            StHigh: begin
                if (in_valid && clr_c) begin
                    if (HOLD == 1) begin
                        state_d = StLow;
                        cnt_d   = '0;
                    end else begin
                        state_d = StFallPend;
                        cnt_d   = CW'(1);
                    end
                end
            end
            StFallPend: begin
                if (in_valid) begin
                    if (clr_c && last_c) begin
                        state_d = StLow;
                        cnt_d   = '0;
                    end else if (clr_c) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        state_d = StHigh;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        out     = (state_q == StHigh) || (state_q == StFallPend);
        out_nxt = (state_d == StHigh) || (state_d == StFallPend);
        flip    = flip_q;
    end

endmodule

// File: rtl/hc_multi.sv
// N-channel hysteresis comparator: independent hc_chan instances sharing valid and threshold.
// any_out is registered from the channels' next-state outputs so it always matches |out.
module hc_multi
    import hc_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned HOLD = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [NCH*W-1:0]   a,
    input  logic [NCH*W-1:0]   b,
    input  logic [W-1:0]       th,
    output logic [NCH-1:0]     out,
    output logic [NCH-1:0]     flip,
    output logic               any_out
);

    logic [NCH-1:0] out_nxt;
    logic           any_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        hc_chan #(
            .W    (W),
            .HOLD (HOLD)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .a        (a[i*W +: W]),
            .b        (b[i*W +: W]),
            .th       (th),
            .out      (out[i]),
            .out_nxt  (out_nxt[i]),
            .flip     (flip[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |out_nxt;
        end
    end

    assign any_out = any_q;

endmodule

// File: tb/tb_hc_multi.sv
// Directed bench for hc_multi (NCH=4, W=8, HOLD=3) with hand-computed expectations.
module tb_hc_multi;

    localparam int NCH  = 4;
    localparam int W    = 8;
    localparam int HOLD = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [W-1:0]     th;
    logic [W-1:0]     av [NCH];
    logic [W-1:0]     bv [NCH];
    logic [NCH*W-1:0] a, b;
    logic [NCH-1:0]   out, flip;
    logic             any_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        a = '0;
        b = '0;
        for (int i = 0; i < NCH; i++) begin
            a[i*W +: W] = av[i];
            b[i*W +: W] = bv[i];
        end
    end

    hc_multi #(
        .NCH  (NCH),
        .W    (W),
        .HOLD (HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .th       (th),
        .out      (out),
        .flip     (flip),
        .any_out  (any_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input int x, input int y);
        av[ch] = W'(x);
        bv[ch] = W'(y);
    endtask

    task automatic set_all(input int x, input int y);
        for (int i = 0; i < NCH; i++) set_ch(i, x, y);
    endtask

    task automatic chk(input string tag, input logic [3:0] eo, input logic [3:0] ef);
        check({tag, ".out"}, 32'(out), 32'(eo));
        check({tag, ".flip"}, 32'(flip), 32'(ef));
        check({tag, ".any"}, 32'(any_out), 32'(|eo));
    endtask

    initial begin
        // Reset held with qualifying data on every channel
        rst      = 1'b0;
        in_valid = 1'b1;
        th       = 8'd5;
        set_all(10, 0);
        step();
        step();
        chk("reset", 4'h0, 4'h0);
        rst = 1'b1;
        step();
        chk("rel_s1", 4'h0, 4'h0);
        step();
        chk("rel_s2", 4'h0, 4'h0);
        step();
        chk("all_rise", 4'hf, 4'hf);
        set_all(0, 10);
        step();
        chk("all_fall_s1", 4'hf, 4'h0);
        step();
        step();
        chk("all_fall", 4'h0, 4'hf);
        set_all(0, 0);
        step();
        chk("idle", 4'h0, 4'h0);

        // ch0 set, strict-threshold hold, clear
        set_ch(0, 10, 4);
        step();
        step();
        chk("c0_s2", 4'h0, 4'h0);
        step();
        chk("c0_set", 4'h1, 4'h1);
        set_ch(0, 4, 9);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("c0_strict", 4'h1, 4'h0);
        end
        set_ch(0, 4, 10);
        step();
        step();
        chk("c0_clr_s2", 4'h1, 4'h0);
        step();
        chk("c0_clr", 4'h0, 4'h1);
        set_ch(0, 0, 0);
        step();
        chk("c0_after", 4'h0, 4'h0);

        // ch1 interrupted run
        set_ch(1, 10, 0);
        step();
        step();
        set_ch(1, 0, 0);
        step();
        set_ch(1, 10, 0);
        step();
        step();
        chk("c1_interrupt", 4'h0, 4'h0);
        step();
        chk("c1_set", 4'h2, 4'h2);
        set_ch(1, 0, 0);

        // ch2 with valid gaps V,0,V,0,0,V
        set_ch(2, 10, 0);
        begin
            logic [5:0] vpat;
            vpat = 6'b100101;
            for (int i = 0; i < 6; i++) begin
                in_valid = vpat[i];
                step();
                if (i < 5) chk("c2_gap", 4'h2, 4'h0);
                else       chk("c2_set", 4'h6, 4'h4);
            end
        end
        in_valid = 1'b1;
        set_ch(2, 0, 0);

        // ch3 range extremes
        set_ch(3, 127, -128);
        th = 8'd255;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("c3_th255", 4'h6, 4'h0);
        end
        th = 8'd254;
        step();
        step();
        chk("c3_s2", 4'h6, 4'h0);
        step();
        chk("c3_set", 4'he, 4'h8);
        set_ch(3, -128, 127);
        step();
        step();
        chk("c3_clr_s2", 4'he, 4'h0);
        step();
        chk("c3_clr", 4'h6, 4'h8);
        set_ch(3, 0, 0);

        // Reset while ch0 is in FALL_PEND with cnt=2
        th = 8'd5;
        set_ch(0, 10, 0);
        step();
        step();
        step();
        chk("c0_reset_set", 4'h7, 4'h1);
        set_ch(0, 0, 10);
        step();
        step();
        chk("c0_fallpend", 4'h7, 4'h0);
        check("c0_cnt2", 32'(dut.g_ch[0].u_chan.cnt_q), 32'd2);
        rst = 1'b0;
        step();
        chk("mid_reset", 4'h0, 4'h0);
        check("c0_cnt0", 32'(dut.g_ch[0].u_chan.cnt_q), 32'd0);
        rst = 1'b1;
        step();
        chk("post_reset", 4'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hc_multi.md
Name: hc_multi

Overview:
- N-channel hysteresis comparator, the parametrised successor of the fixed 8-bit, single-pair, fixed-threshold comparator.
- Each channel compares a signed pair (a_i, b_i) against a runtime threshold `th`.
- A channel's output flips only after the opposing condition has held for HOLD consecutive valid samples. This adds persistence filtering, sample gating, overflow-safe arithmetic and change pulses.
- Sits between per-channel sample sources and downstream event/interrupt logic.

Parameters:
- NCH, 4, number of independent channels (1..32).
- W, 8, sample width in bits, signed two's complement.
- HOLD, 3, consecutive qualifying valid samples required to flip (1..255).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low; rst==0 at a rising edge resets the block.
- in_valid  in  1  samples on a/b are consumed this cycle.
- a  in  NCH*W  channel i at a[i*W +: W], signed.
- b  in  NCH*W  channel i at b[i*W +: W], signed.
- th  in  W  hysteresis threshold, unsigned; sampled every valid cycle.
- out  out  NCH  1 when channel i is in the A-greater region.
- flip  out  NCH  one-cycle pulse when out[i] changes.
- any_out  out  1  registered OR of next-state out bits; equals |out every cycle.

Behaviour:
- Reset (rst==0 at edge): every channel goes to LOW with cnt=0; out=0, flip=0, any_out=0. Reset overrides in_valid. Reset mid-pend or in HIGH still gives all zeros the next cycle.
- Arithmetic:
  - d = a_i - b_i, computed sign-extended to W+2 bits; no wrap.
  - th is zero-extended to W+2 bits.
  - set_c = (d > th); clr_c = (-d > th). Both are strict.
  - th=0 gives a plain comparator; equal inputs never flip.
- Per-channel FSM, states LOW, RISE_PEND, HIGH, FALL_PEND; cnt is an 8-bit counter.
- LOW:
  - valid & set_c: if HOLD==1 go HIGH; else go RISE_PEND with cnt=1.
  - Otherwise stay.
- RISE_PEND:
  - valid & set_c & cnt==HOLD-1: go HIGH, cnt=0.
  - valid & set_c: cnt+1.
  - valid & !set_c: go LOW, cnt=0.
  - !valid: hold state and cnt.
- HIGH and FALL_PEND mirror LOW and RISE_PEND, using clr_c and returning to LOW.
- out[i] = state is HIGH or FALL_PEND. It is registered and changes on the edge that consumes the HOLD-th qualifying sample.
- flip[i] is registered and asserted in exactly the cycle out[i] first shows the new value. It is deasserted the next cycle unless another flip occurs.
- Gating: cycles with in_valid==0 neither advance nor clear pend counters. Qualification requires HOLD consecutive valid samples, not consecutive cycles.
- Channels are fully independent; simultaneous flips on several channels are allowed.
- Illegal state encoding goes to LOW, cnt=0.
- No combinational path from inputs to outputs.

Decomposition:
- Package hc_pkg holds:
  - state enum {LOW, RISE_PEND, HIGH, FALL_PEND} as a 2-bit type;
  - localparam CW=8;
  - the function for the sign-extended difference.
- Sub-module hc_chan implements one channel: FSM, counter and compare; parameters W and HOLD.
- hc_multi instantiates hc_chan via generate over NCH and builds any_out.

Test Plan (NCH=4, W=8, HOLD=3, th=5 unless noted):
1. Reset: hold rst=0 for 2 edges with arbitrary a/b and valid=1 -> out=0, flip=0, any_out=0. Release rst -> still 0 until 3 qualifying samples.
2. Set/clear:
   - ch0 a=10, b=4 (d=6), valid for 3 cycles -> out[0]=1 after the 3rd edge, flip[0]=1 for one cycle, any_out=1.
   - Then a=4, b=9 (-d=5) for 10 cycles -> stays 1 (strict).
   - Then a=4, b=10 for 3 cycles -> out[0]=0, with a flip pulse.
3. Interrupted run: ch1 set_c for 2 samples, then a=b=0 for 1 sample, then set_c for 2 samples -> out[1] stays 0. A 3rd qualifying sample -> out[1]=1.
4. Valid gaps: ch2 set_c samples interleaved with in_valid=0 cycles (pattern V,0,V,0,0,V) -> out[2]=1 on the 3rd valid edge. Gap cycles do not reset cnt.
5. Overflow: ch3 a=127, b=-128, th=255 -> d=255, not > th, no flip. th=254 -> sets after 3 samples. Then a=-128, b=127, th=254 -> clears. No wrap-around misfire.
6. Mixed:
   - All 4 channels reach HOLD on the same edge -> flip=4'b1111 for one cycle.
   - Assert rst=0 while ch0 is in FALL_PEND with cnt=2 -> next cycle out=0, flip=0, cnt=0.
